// File: rtl/pkt_pingpong_write_pkg.sv
// Shared definitions for the ping-pong beat writer: beat types, beat width,
// FSM encodings and the default per-packet beat limit.
package pkt_pingpong_write_pkg;

    localparam int BEAT_W        = 134;
    localparam int MAX_BEATS_DEF = 128;
    localparam int BEAT_CNT_W    = 8;

    typedef enum logic [1:0] {
        BT_INV  = 2'b00,
        BT_HEAD = 2'b01,
        BT_TAIL = 2'b10,
        BT_MID  = 2'b11
    } beat_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DISC = 2'd2
    } state_e;

    function automatic beat_type_e beat_type(input logic [BEAT_W-1:0] beat);
        return beat_type_e'(beat[BEAT_W-1 -: 2]);
    endfunction

endpackage

// File: rtl/pkt_pingpong_write_sat_counter.sv
// Saturating event counter: increments on i_inc and sticks at all-ones.
module ppw_sat_counter
    import pkt_pingpong_write_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] ov_cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ov_cnt = cnt_q;

endmodule

// File: rtl/pkt_pingpong_write.sv
// Steers a framed beat stream alternately into two holding registers for the
// downstream PCB writer. Define PPW_TRUNC_EN to enable MAX_BEATS truncation.
module pkt_pingpong_write
    import pkt_pingpong_write_pkg::*;
#(
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [BEAT_W-1:0] iv_data,
    input  logic              i_data_wr,
    output logic              o_data_ready,
    output logic [BEAT_W-1:0] ov_data1,
    output logic              o_data1_write_flag,
    input  logic              i_data1_read,
    output logic [BEAT_W-1:0] ov_data2,
    output logic              o_data2_write_flag,
    input  logic              i_data2_read,
    output logic [CNT_W-1:0]  ov_trunc_cnt,
    output logic [CNT_W-1:0]  ov_orphan_cnt,
    output logic [1:0]        ov_dbg_state
);

    if (MAX_BEATS < 2 || MAX_BEATS > 255) begin : g_bad_max_beats
        $error("MAX_BEATS must lie in 2..255");
    end

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              full1_q, full1_d;
    logic              full2_q, full2_d;
    logic [BEAT_W-1:0] data1_q, data1_d;
    logic [BEAT_W-1:0] data2_q, data2_d;
    logic              wflag1_q, wflag1_d;
    logic              wflag2_q, wflag2_d;
`ifdef PPW_TRUNC_EN
    logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  trunc_inc;
`endif

    logic              target;
    logic              accept;
    beat_type_e        btype;
    logic              wr_en;
    logic              wr_sel;
    logic [BEAT_W-1:0] wr_beat;
    logic              orphan_inc;

    // Every packet starts in reg1, so an idle stage waits on reg1 regardless of r_sel.
    assign target       = (state_q == ST_IDLE) ? 1'b0 : sel_q;
    assign o_data_ready = (state_q == ST_DISC) || (target ? !full2_q : !full1_q);
    assign accept       = i_data_wr && o_data_ready;
    assign btype        = beat_type(iv_data);

    always_comb begin
        state_d    = state_q;
        wr_en      = 1'b0;
        wr_sel     = sel_q;
        wr_beat    = iv_data;
        orphan_inc = 1'b0;
`ifdef PPW_TRUNC_EN
        cnt_d      = cnt_q;
        trunc_inc  = 1'b0;
`endif
        if (accept) begin
            if (btype == BT_INV) begin
                orphan_inc = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (btype == BT_HEAD) begin
                            wr_en   = 1'b1;
                            wr_sel  = 1'b0;
                            state_d = ST_FWD;
`ifdef PPW_TRUNC_EN
                            cnt_d   = BEAT_CNT_W'(1);
`endif
                        end else begin
                            orphan_inc = 1'b1;
                        end
                    end
                    ST_FWD: begin
                        if (btype == BT_HEAD) begin
                            orphan_inc = 1'b1;
                            state_d    = ST_DISC;
                        end else if (btype == BT_TAIL) begin
                            wr_en   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            wr_en = 1'b1;
`ifdef PPW_TRUNC_EN
                            // Last line of the buffer: close the packet with a synthetic tail.
                            if (cnt_q >= BEAT_CNT_W'(MAX_BEATS - 1)) begin
                                wr_beat   = {BT_TAIL, iv_data[BEAT_W-3:0]};
                                trunc_inc = 1'b1;
                                state_d   = ST_DISC;
                            end else begin
                                cnt_d = cnt_q + BEAT_CNT_W'(1);
                            end
`endif
                        end
                    end
                    ST_DISC: begin
                        if (btype == BT_TAIL) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        sel_d    = wr_en ? !wr_sel : sel_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        wflag1_d = 1'b0;
        wflag2_d = 1'b0;
        full1_d  = i_data1_read ? 1'b0 : full1_q;
        full2_d  = i_data2_read ? 1'b0 : full2_q;
        if (wr_en && !wr_sel) begin
            data1_d  = wr_beat;
            wflag1_d = 1'b1;
            full1_d  = 1'b1;
        end
        if (wr_en && wr_sel) begin
            data2_d  = wr_beat;
            wflag2_d = 1'b1;
            full2_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= 1'b0;
            full1_q  <= 1'b0;
            full2_q  <= 1'b0;
            data1_q  <= '0;
            data2_q  <= '0;
            wflag1_q <= 1'b0;
            wflag2_q <= 1'b0;
`ifdef PPW_TRUNC_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            full1_q  <= full1_d;
            full2_q  <= full2_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            wflag1_q <= wflag1_d;
            wflag2_q <= wflag2_d;
`ifdef PPW_TRUNC_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign ov_data1           = data1_q;
    assign ov_data2           = data2_q;
    assign o_data1_write_flag = wflag1_q;
    assign o_data2_write_flag = wflag2_q;
    assign ov_dbg_state       = state_q;

    ppw_sat_counter #(.W(CNT_W)) u_orphan_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_inc  (orphan_inc),
        .ov_cnt (ov_orphan_cnt)
    );

`ifdef PPW_TRUNC_EN
    ppw_sat_counter #(.W(CNT_W)) u_trunc_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_inc  (trunc_inc),
        .ov_cnt (ov_trunc_cnt)
    );
`else
    assign ov_trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_pingpong_write.sv
// Directed bench for pkt_pingpong_write: expected register writes are queued
// as stimulus is issued and checked by an independent write-flag monitor.
module tb_pkt_pingpong_write;

    localparam int CNT_W = 16;
    localparam logic [1:0] T_INV = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_MID = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic [133:0]     data;
    logic             wr;
    logic             ready;
    logic [133:0]     data1, data2;
    logic             wf1, wf2;
    logic             rd1, rd2;
    logic [CNT_W-1:0] trunc_cnt, orphan_cnt;
    logic [1:0]       dbg_state;

    logic rd1_auto = 1'b0, rd2_auto = 1'b0, rd1_man, rd2_man;
    logic pend1 = 1'b0, pend2 = 1'b0;
    logic auto1_en, auto2_en;

    logic [134:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    assign rd1 = rd1_auto | rd1_man;
    assign rd2 = rd2_auto | rd2_man;

    pkt_pingpong_write #(.MAX_BEATS(128), .CNT_W(CNT_W)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .iv_data            (data),
        .i_data_wr          (wr),
        .o_data_ready       (ready),
        .ov_data1           (data1),
        .o_data1_write_flag (wf1),
        .i_data1_read       (rd1),
        .ov_data2           (data2),
        .o_data2_write_flag (wf2),
        .i_data2_read       (rd2),
        .ov_trunc_cnt       (trunc_cnt),
        .ov_orphan_cnt      (orphan_cnt),
        .ov_dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [133:0] mk(input logic [1:0] t, input int n);
        return {t, 100'd0, 32'(n)};
    endfunction

    task automatic check_val(input string name, input logic [134:0] act, input logic [134:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic reg_id, input logic [133:0] beat);
        exp_q.push_back({reg_id, beat});
    endtask

    task automatic mon_write(input logic reg_id, input logic [133:0] beat);
        logic [134:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got reg%0d %h expected no write", reg_id + 1, beat);
        end else begin
            e = exp_q.pop_front();
            check_val("reg_write", {reg_id, beat}, e);
        end
    endtask

    // Monitor: every write flag must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (wf1) mon_write(1'b0, data1);
            if (wf2) mon_write(1'b1, data2);
        end
    end

    // Downstream model: echoes a read pulse one cycle after each write flag.
    always @(negedge clk) begin
        rd1_auto = pend1;
        rd2_auto = pend2;
        pend1 = auto1_en && wf1;
        pend2 = auto2_en && wf2;
    end

    task automatic send(input logic [133:0] b);
        int waited = 0;
        data = b;
        wr   = 1'b1;
        while (!ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: ready got 0 expected 1 for beat %h", b);
        end else begin
            @(negedge clk);
        end
        wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [1:0] t;
        logic [133:0] b;
        rst = 1'b1; wr = 1'b0; data = '0;
        rd1_man = 1'b0; rd2_man = 1'b0;
        auto1_en = 1'b1; auto2_en = 1'b1;
        idle(3);
        check_val("rst_data1", data1, 0);
        check_val("rst_data2", data2, 0);
        check_val("rst_flags", {wf1, wf2}, 0);
        check_val("rst_ready", ready, 1);
        check_val("rst_trunc", trunc_cnt, 0);
        check_val("rst_orphan", orphan_cnt, 0);
        rst = 1'b0;
        idle(2);

        // 3-beat packet, reads echoed: reg1, reg2, reg1.
        push_exp(1'b0, mk(T_HEAD, 1));
        push_exp(1'b1, mk(T_MID, 2));
        push_exp(1'b0, mk(T_TAIL, 3));
        send(mk(T_HEAD, 1));
        send(mk(T_MID, 2));
        send(mk(T_TAIL, 3));
        idle(4);
        check_val("pkt3_state_idle", dbg_state, 0);
        check_val("pkt3_orphan", orphan_cnt, 0);
        check_val("pkt3_trunc", trunc_cnt, 0);

        // Orphans in IDLE: middle then invalid, no writes.
        send(mk(T_MID, 10));
        send(mk(T_INV, 11));
        idle(3);
        check_val("orphan_two", orphan_cnt, 2);

        // Back-pressure: both regs full, target reg1 blocks the tail.
        auto1_en = 1'b0; auto2_en = 1'b0;
        idle(3);
        push_exp(1'b0, mk(T_HEAD, 20));
        push_exp(1'b1, mk(T_MID, 21));
        push_exp(1'b0, mk(T_TAIL, 22));
        send(mk(T_HEAD, 20));
        send(mk(T_MID, 21));
        check_val("bp_ready_low", ready, 0);
        data = mk(T_TAIL, 22);
        wr = 1'b1;
        @(negedge clk);
        check_val("bp_ready_still_low", ready, 0);
        rd1_man = 1'b1;
        @(negedge clk);
        rd1_man = 1'b0;
        check_val("bp_ready_after_read1", ready, 1);
        @(negedge clk);
        wr = 1'b0;
        idle(2);
        check_val("bp_state_idle", dbg_state, 0);
        rd1_man = 1'b1; rd2_man = 1'b1;
        @(negedge clk);
        rd1_man = 1'b0; rd2_man = 1'b0;
        auto1_en = 1'b1; auto2_en = 1'b1;
        idle(2);

        // Head during FWD: dropped, DISC until tail, then normal packet.
        push_exp(1'b0, mk(T_HEAD, 30));
        push_exp(1'b1, mk(T_MID, 31));
        send(mk(T_HEAD, 30));
        send(mk(T_MID, 31));
        send(mk(T_HEAD, 32));
        check_val("disc_state", dbg_state, 2);
        check_val("disc_orphan", orphan_cnt, 3);
        send(mk(T_MID, 33));
        send(mk(T_TAIL, 34));
        check_val("disc_exit_idle", dbg_state, 0);
        push_exp(1'b0, mk(T_HEAD, 35));
        push_exp(1'b1, mk(T_TAIL, 36));
        send(mk(T_HEAD, 35));
        send(mk(T_TAIL, 36));
        idle(4);
        check_val("disc_orphan_final", orphan_cnt, 3);

        // 130-beat packet: truncation at beat 128 when enabled.
        for (int i = 1; i <= 130; i++) begin
            t = (i == 1) ? T_HEAD : ((i == 130) ? T_TAIL : T_MID);
            b = mk(t, 100 + i);
`ifdef PPW_TRUNC_EN
            if (i <= 127) push_exp(i[0] ? 1'b0 : 1'b1, b);
            else if (i == 128) push_exp(1'b1, mk(T_TAIL, 100 + i));
`else
            push_exp(i[0] ? 1'b0 : 1'b1, b);
`endif
            send(b);
        end
        idle(4);
`ifdef PPW_TRUNC_EN
        check_val("long_trunc_cnt", trunc_cnt, 1);
`else
        check_val("long_trunc_cnt", trunc_cnt, 0);
`endif
        check_val("long_orphan", orphan_cnt, 3);
        check_val("long_state_idle", dbg_state, 0);
        push_exp(1'b0, mk(T_HEAD, 300));
        push_exp(1'b1, mk(T_TAIL, 301));
        send(mk(T_HEAD, 300));
        send(mk(T_TAIL, 301));
        idle(4);

        // Reset mid-packet with both regs held full.
        auto1_en = 1'b0; auto2_en = 1'b0;
        idle(3);
        push_exp(1'b0, mk(T_HEAD, 400));
        push_exp(1'b1, mk(T_MID, 401));
        send(mk(T_HEAD, 400));
        send(mk(T_MID, 401));
        @(negedge clk);
        check_val("pre_rst_ready", ready, 0);
        rst = 1'b1;
        #1;
        check_val("mid_rst_data1", data1, 0);
        check_val("mid_rst_data2", data2, 0);
        check_val("mid_rst_flags", {wf1, wf2}, 0);
        check_val("mid_rst_ready", ready, 1);
        check_val("mid_rst_orphan", orphan_cnt, 0);
        check_val("mid_rst_trunc", trunc_cnt, 0);
        check_val("mid_rst_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;
        auto1_en = 1'b1; auto2_en = 1'b1;
        send(mk(T_MID, 402));
        send(mk(T_MID, 403));
        idle(4);
        check_val("post_rst_orphan", orphan_cnt, 2);
        check_val("exp_queue_drained", 135'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
